// File: rtl/abr_prim_diff_sender.sv
// Transmit end of the differential event link: drives req_i as a complementary pair and runs a
// four-phase handshake against the returned ack pair. ABR_DIFF_SENDER_TIMEOUT_EN enables stall aborts.
module abr_prim_diff_sender #(
   parameter int PulseCycles = 2,
   parameter int AckTimeout  = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   output logic ack_o,
   output logic diff_po,
   output logic diff_no,
   input  logic ack_pi,
   input  logic ack_ni,
   output logic busy_o,
   output logic timeout_o,
   output logic sigint_o
);

`ifdef ABR_DIFF_SENDER_TIMEOUT_EN
   localparam int CntW   = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
   localparam int CntSat = AckTimeout - 1;
`else
   localparam int CntW   = (PulseCycles > 1) ? $clog2(PulseCycles) : 1;
   localparam int CntSat = (PulseCycles > 1) ? PulseCycles - 1 : 0;
`endif
   localparam logic [CntW-1:0] CntMax  = CntW'(CntSat);
   localparam logic [CntW-1:0] HoldMin = CntW'(PulseCycles - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DRAIN   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ack_lvl_q, ack_lvl_d;
   logic            ack_q, ack_d;
   logic            timeout_q, timeout_d;
   logic            sigint_q, sigint_d;
   logic            diff_p_q, diff_p_d;
   logic            diff_n_q, diff_n_d;

   logic ack_ok, ack_hi, ack_lo, expired, done, tmo;

   assign ack_ok    = ack_pi ^ ack_ni;
   assign ack_lvl_d = ack_ok ? ack_pi : ack_lvl_q;
   // Handshake edges only count on a well-formed pair; during a fault only expiry can move the FSM.
   assign ack_hi    = ack_ok & ack_lvl_d;
   assign ack_lo    = ack_ok & ~ack_lvl_d;

`ifdef ABR_DIFF_SENDER_TIMEOUT_EN
   assign expired = (cnt_q == CntMax);
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ack_lvl_q <= 1'b0;
         ack_q     <= 1'b0;
         timeout_q <= 1'b0;
         sigint_q  <= 1'b0;
         diff_p_q  <= 1'b0;
         diff_n_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ack_lvl_q <= ack_lvl_d;
         ack_q     <= ack_d;
         timeout_q <= timeout_d;
         sigint_q  <= sigint_d;
         diff_p_q  <= diff_p_d;
         diff_n_q  <= diff_n_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      tmo     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_i && !ack_q) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (ack_hi && cnt_q >= HoldMin) begin
               state_d = ST_RELEASE;
            end else if (expired) begin
               state_d = ST_DRAIN;
               tmo     = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (ack_lo) begin
               state_d = ST_IDLE;
               done    = 1'b1;
            end else if (expired) begin
               state_d = ST_DRAIN;
               tmo     = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (ack_lo) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == ST_ASSERT || state_q == ST_RELEASE) && cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      ack_d     = done | tmo;
      timeout_d = tmo;
      sigint_d  = ~ack_ok;
      diff_p_d  = (state_d == ST_ASSERT);
      diff_n_d  = ~diff_p_d;
   end

   assign ack_o     = ack_q;
   assign timeout_o = timeout_q;
   assign sigint_o  = sigint_q;
   assign diff_po   = diff_p_q;
   assign diff_no   = diff_n_q;
   assign busy_o    = (state_q != ST_IDLE);

`ifdef ABR_ASSERT
   a_pair_compl: assert property (@(posedge clk_i) disable iff (rst_i) diff_po != diff_no);
   a_tmo_ack:    assert property (@(posedge clk_i) disable iff (rst_i) timeout_o |-> ack_o);
   a_sig_hold:   assert property (@(posedge clk_i) disable iff (rst_i)
                    (sigint_o && !ack_ok && state_q != ST_IDLE && !tmo) |=> $stable(state_q));
`endif

endmodule

// File: tb/tb_abr_prim_diff_sender.sv
// Scoreboarded random bench for abr_prim_diff_sender: a transaction-level model predicts pulse length,
// ack/timeout timing and return to idle for each request; a negedge monitor checks the DUT against it.
module tb_abr_prim_diff_sender;
   localparam int P   = 2;
   localparam int T   = 16;
   localparam int LIM = 400;
`ifdef ABR_DIFF_SENDER_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   logic req_i = 1'b0;
   logic ack_pi = 1'b0;
   logic ack_ni = 1'b1;
   logic ack_o, diff_po, diff_no, busy_o, timeout_o, sigint_o;

   abr_prim_diff_sender #(.PulseCycles(P), .AckTimeout(T)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .ack_o(ack_o),
      .diff_po(diff_po), .diff_no(diff_no), .ack_pi(ack_pi), .ack_ni(ack_ni),
      .busy_o(busy_o), .timeout_o(timeout_o), .sigint_o(sigint_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t0;
      int ack;
      int tmo;
      int pulse;
      int idle;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Ack pair schedule relative to the request: 2 = malformed pair, 1 = high, 0 = low.
   function automatic int ack_at(int k, int r, int f, int fs, int fl);
      if (k >= fs && k < fs + fl) return 2;
      if (k >= f) return 0;
      if (k >= r) return 1;
      return 0;
   endfunction

   function automatic exp_t model(int t0, int r, int f, int fs, int fl);
      exp_t e;
      int u, v, dr, lim_a, lim_r;
      u = -1; v = -1; dr = -1;
      e.t0 = t0; e.tmo = 0; e.idle = 0; e.ack = 0; e.pulse = 0;
      lim_a = TMO ? T : 1000;
      for (int k = P; k <= lim_a; k++)
         if (ack_at(k, r, f, fs, fl) == 1) begin u = k; break; end
      if (u < 0) begin
         e.tmo = 1; e.pulse = T; e.ack = T + 1; dr = T + 1;
      end else begin
         e.pulse = u;
         lim_r = TMO ? u + T : u + 1000;
         for (int k = u + 1; k <= lim_r; k++)
            if (ack_at(k, r, f, fs, fl) == 0) begin v = k; break; end
         if (v < 0) begin
            e.tmo = 1; e.ack = u + T + 1; dr = u + T + 1;
         end else begin
            e.ack = v + 1; e.idle = v + 1;
         end
      end
      if (dr >= 0)
         for (int k = dr; k < dr + 1000; k++)
            if (ack_at(k, r, f, fs, fl) == 0) begin e.idle = k + 1; break; end
      e.ack  += t0;
      e.idle += t0;
      return e;
   endfunction

   task automatic drive_pair(int s, bit fpat);
      case (s)
         2:       begin ack_pi = fpat;  ack_ni = fpat; end
         1:       begin ack_pi = 1'b1;  ack_ni = 1'b0; end
         default: begin ack_pi = 1'b0;  ack_ni = 1'b1; end
      endcase
   endtask

   task automatic run_txn(int r, int f, int fs, int fl, bit fpat);
      bit seen;
      int k;
      seen = 1'b0;
      @(posedge clk); #1;
      q.push_back(model(cyc, r, f, fs, fl));
      for (k = 0; k < LIM; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         req_i = !seen;
         drive_pair(ack_at(k, r, f, fs, fl), fpat);
         @(negedge clk);
         if (ack_o) seen = 1'b1;
         if (seen && !busy_o && k >= f) break;
      end
      if (k >= LIM) chk("txn_bound", 32'(seen), 32'd1);
      req_i = 1'b0;
   endtask

   // Monitor / scoreboard
   bit prev_po = 1'b0, prev_rst = 1'b1, prev_fault = 1'b0;
   int rise_cyc = -1, last_len = -1, pend_idle = -1;

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (prev_rst) begin
            chk("rst_diff_po", 32'(diff_po), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_ack", 32'(ack_o), 32'd0);
            chk("rst_timeout", 32'(timeout_o), 32'd0);
            rise_cyc  = -1;
            pend_idle = -1;
         end
         chk("pair_compl", 32'(diff_po ^ diff_no), 32'd1);
         chk("sigint", 32'(sigint_o), 32'(prev_rst ? 1'b0 : prev_fault));
         if (timeout_o) chk("timeout_without_ack", 32'(ack_o), 32'd1);
         if (diff_po && !prev_po) begin
            rise_cyc = cyc;
            chk("busy_on_rise", 32'(busy_o), 32'd1);
         end
         if (!diff_po && prev_po) last_len = cyc - rise_cyc;
         if (ack_o) begin
            if (q.size() == 0) begin
               chk("unexpected_ack", 32'(ack_o), 32'd0);
            end else begin
               e = q.pop_front();
               chk("ack_cycle", 32'(cyc), 32'(e.ack));
               chk("timeout_flag", 32'(timeout_o), 32'(e.tmo));
               chk("pulse_len", 32'(last_len), 32'(e.pulse));
               chk("req_latency", 32'(rise_cyc), 32'(e.t0 + 1));
               pend_idle = e.idle;
            end
         end
         if (pend_idle >= 0 && !busy_o) begin
            chk("idle_cycle", 32'(cyc), 32'(pend_idle));
            pend_idle = -1;
         end
      end
      prev_po    = diff_po;
      prev_rst   = rst_i;
      prev_fault = ~(ack_pi ^ ack_ni);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int r, f, fs, fl;
      bit fpat;
      // Reset with random inputs
      rst_i = 1'b1;
      req_i = 1'($urandom_range(1, 0)); ack_pi = 1'($urandom_range(1, 0)); ack_ni = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      req_i = 1'($urandom_range(1, 0)); ack_pi = 1'($urandom_range(1, 0)); ack_ni = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      rst_i = 1'b0; req_i = 1'b0; ack_pi = 1'b0; ack_ni = 1'b1;
      @(negedge clk);
      chk("reset_diff_po", 32'(diff_po), 32'd0);
      chk("reset_diff_no", 32'(diff_no), 32'd1);
      chk("reset_ack", 32'(ack_o), 32'd0);
      chk("reset_timeout", 32'(timeout_o), 32'd0);
      chk("reset_sigint", 32'(sigint_o), 32'd0);
      chk("reset_busy", 32'(busy_o), 32'd0);
      mon_en = 1'b1;

      run_txn(4, 7, 0, 0, 1'b0);      // normal handshake
      run_txn(1, 5, 0, 0, 1'b0);      // early ack, hold governs
      run_txn(110, 115, 0, 0, 1'b0);  // stalled ack: abort when enabled, waits otherwise
      run_txn(2, 10, 2, 3, 1'b1);     // malformed pair during Assert

      // Reset in the middle of Assert
      @(posedge clk); #1; req_i = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; rst_i = 1'b1;
      @(posedge clk); #1; rst_i = 1'b0; req_i = 1'b0;
      @(negedge clk);
      chk("midrst_diff_po", 32'(diff_po), 32'd0);
      chk("midrst_diff_no", 32'(diff_no), 32'd1);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_ack", 32'(ack_o), 32'd0);
      repeat (5) @(posedge clk);
      run_txn(3, 6, 0, 0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         r    = $urandom_range(20, 1);
         fl   = ($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0;
         fs   = $urandom_range(8, 1);
         fpat = 1'($urandom_range(1, 0));
         f    = r;
         if (fs + fl > f) f = fs + fl;
         if (P > f) f = P;
         f    = f + $urandom_range(20, 1);
         run_txn(r, f, fs, fl, fpat);
         repeat ($urandom_range(3, 0)) @(posedge clk);
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
